// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and constants for the round-robin counter scheduler.
//   sched_state_t : scheduler FSM state encoding (IDLE, LOAD, RUN, DONE)
//   WIDTH_DEFAULT : default counter / duration width
//   NREQ_MAX      : largest supported number of requesters
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    localparam int WIDTH_DEFAULT = 8;
    localparam int NREQ_MAX      = 8;

endpackage

// File: rtl/counter_scheduler_if.sv
// -----------------------------------------------------------------------------
// counter_scheduler_if
// Request/grant bundle between requesters and the counter scheduler.
//   req      : level request, one bit per requester
//   dur      : requested duration per requester (sampled at the grant edge)
//   hold     : freezes the counter while running
//   abort    : cancels the active job
//   grant    : one-hot owner, or all zero
//   done     : one-cycle completion pulse to the owner
//   busy     : high whenever grant is non-zero
//   contador : live counter value
// Modports: master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface counter_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]            req;
    logic [NREQ-1:0][WIDTH-1:0] dur;
    logic                       hold;
    logic                       abort;
    logic [NREQ-1:0]            grant;
    logic [NREQ-1:0]            done;
    logic                       busy;
    logic [WIDTH-1:0]           contador;

    modport master (
        output req, dur, hold, abort,
        input  grant, done, busy, contador
    );

    modport slave (
        input  req, dur, hold, abort,
        output grant, done, busy, contador
    );
endinterface

// File: rtl/count8_core.sv
// -----------------------------------------------------------------------------
// count8_core
// Unsigned up-counter with synchronous clear (priority) and enable.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset, counter returns to 0
//   enable   : increment by one this cycle
//   clear    : synchronous clear to 0, wins over enable
//   contador : current count
// -----------------------------------------------------------------------------
module count8_core
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] contador
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_r;

    // Counter register: clear first, then increment, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (enable) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign contador = count_r;

endmodule

// File: rtl/counter_scheduler.sv
// -----------------------------------------------------------------------------
// counter_scheduler
// Round-robin owner of a shared up-counter. Grants one requester at a time,
// clears and runs the counter up to the latched duration, then pulses done
// to the owner. Only the IDLE state arbitrates, so there is always at least
// one IDLE cycle between consecutive grants.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : counter_scheduler_if.slave (req, dur, hold, abort -> grant, done,
//         busy, contador); all outputs are registered.
// -----------------------------------------------------------------------------
module counter_scheduler
    import counter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    counter_scheduler_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
    localparam logic [PW-1:0]   PTR_LAST  = PW'(NREQ - 1);
    localparam logic [NREQ-1:0] GRANT_ONE = NREQ'(1);

    sched_state_t     state_r;
    sched_state_t     next_state_s;
    logic [PW-1:0]    ptr_r;
    logic [NREQ-1:0]  grant_r;
    logic [NREQ-1:0]  done_r;
    logic             busy_r;
    logic [WIDTH-1:0] d_lat_r;

    logic [WIDTH-1:0] contador_s;
    logic             pick_valid_s;
    logic [PW-1:0]    pick_idx_s;
    logic             at_end_s;
    logic             clear_s;
    logic             enable_s;
    logic             take_s;
    logic [NREQ-1:0]  grant_nxt_s;
    logic [NREQ-1:0]  done_nxt_s;

    // First requester at or after the pointer, wrapping modulo NREQ.
    // Scanning downward lets the lowest offset win the last assignment.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   p);
        logic [PW:0]     res;
        logic [NREQ-1:0] r_shift;
        int              idx;
        res = {(PW+1){1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx     = (int'(p) + i) % NREQ;
            r_shift = r >> idx;
            if (r_shift[0]) begin
                res = {1'b1, PW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign {pick_valid_s, pick_idx_s} = rr_pick(bus.req, ptr_r);
    assign at_end_s = (contador_s == d_lat_r);

    count8_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable_s),
        .clear    (clear_s),
        .contador (contador_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; abort only matters in LOAD and RUN.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    next_state_s = IDLE;
                end else if (at_end_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM outputs: counter controls and next values of the output registers.
    always_comb begin
        clear_s     = 1'b0;
        enable_s    = 1'b0;
        take_s      = 1'b0;
        grant_nxt_s = grant_r;
        done_nxt_s  = {NREQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    take_s      = 1'b1;
                    grant_nxt_s = GRANT_ONE << pick_idx_s;
                end else begin
                    grant_nxt_s = {NREQ{1'b0}};
                end
            end
            LOAD: begin
                clear_s = 1'b1;
                if (bus.abort) begin
                    grant_nxt_s = {NREQ{1'b0}};
                end else begin
                    grant_nxt_s = grant_r;
                end
            end
            RUN: begin
                // Abort beats both hold and reaching the end value.
                if (bus.abort) begin
                    clear_s     = 1'b1;
                    grant_nxt_s = {NREQ{1'b0}};
                end else if (at_end_s) begin
                    done_nxt_s = grant_r;
                end else begin
                    enable_s = !bus.hold;
                end
            end
            DONE: begin
                grant_nxt_s = {NREQ{1'b0}};
            end
            default: begin
                grant_nxt_s = {NREQ{1'b0}};
            end
        endcase
    end

    // Output, pointer and duration-latch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_r <= {NREQ{1'b0}};
            done_r  <= {NREQ{1'b0}};
            busy_r  <= 1'b0;
            ptr_r   <= {PW{1'b0}};
            d_lat_r <= {WIDTH{1'b0}};
        end else begin
            grant_r <= grant_nxt_s;
            done_r  <= done_nxt_s;
            busy_r  <= |grant_nxt_s;
            if (take_s) begin
                ptr_r   <= (pick_idx_s == PTR_LAST) ? {PW{1'b0}} : (pick_idx_s + PTR_ONE);
                d_lat_r <= bus.dur[pick_idx_s];
            end else begin
                ptr_r   <= ptr_r;
                d_lat_r <= d_lat_r;
            end
        end
    end

    assign bus.grant    = grant_r;
    assign bus.done     = done_r;
    assign bus.busy     = busy_r;
    assign bus.contador = contador_s;

endmodule

// File: tb/tb_counter_scheduler.sv
// -----------------------------------------------------------------------------
// tb_counter_scheduler
// Directed bench for counter_scheduler (NREQ=4, WIDTH=8). Each task resets
// the block, drives one scenario and compares outputs on the falling edge
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_counter_scheduler;

    logic clk;
    logic rst;
    int   chk_cnt;
    int   pass_cnt;

    counter_scheduler_if #(.NREQ(4), .WIDTH(8)) bus ();

    counter_scheduler #(.NREQ(4), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        bus.req   = 4'b0000;
        bus.dur   = 32'd0;
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        bus.req   = 4'b1111;
        bus.dur   = 32'd0;
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_cnt++;
        if (bus.grant !== 4'b0000) $display("FAIL reset_grant got %b exp 0000", bus.grant); else pass_cnt++;
        chk_cnt++;
        if (bus.done !== 4'b0000) $display("FAIL reset_done got %b exp 0000", bus.done); else pass_cnt++;
        chk_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else pass_cnt++;
        chk_cnt++;
        if (bus.contador !== 8'd0) $display("FAIL reset_contador got %0d exp 0", bus.contador); else pass_cnt++;
        bus.req = 4'b0000;
        rst     = 1'b1;
        step();
        chk_cnt++;
        if (bus.grant !== 4'b0000) $display("FAIL reset_idle_grant got %b exp 0000", bus.grant); else pass_cnt++;
    endtask

    task automatic test_single();
        logic [3:0] exp_g;
        logic [7:0] exp_c;
        do_reset();
        bus.dur[0] = 8'd3;
        bus.req    = 4'b0001;
        for (int n = 0; n < 8; n++) begin
            step();
            if (n == 0) bus.req = 4'b0000;
            exp_g = (n <= 5) ? 4'b0001 : 4'b0000;
            chk_cnt++;
            if (bus.grant !== exp_g) $display("FAIL single_grant n=%0d got %b exp %b", n, bus.grant, exp_g); else pass_cnt++;
            chk_cnt++;
            if (bus.busy !== (n <= 5)) $display("FAIL single_busy n=%0d got %b exp %b", n, bus.busy, (n <= 5)); else pass_cnt++;
            chk_cnt++;
            if (bus.done !== ((n == 5) ? 4'b0001 : 4'b0000))
                $display("FAIL single_done n=%0d got %b", n, bus.done);
            else pass_cnt++;
            if (n >= 1 && n <= 5) begin
                exp_c = (n == 5) ? 8'd3 : 8'(n - 1);
                chk_cnt++;
                if (bus.contador !== exp_c) $display("FAIL single_contador n=%0d got %0d exp %0d", n, bus.contador, exp_c); else pass_cnt++;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [3:0] one;
        do_reset();
        bus.req = 4'b1111;
        one     = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            step();
            exp_g = ((c % 4) < 3) ? (one << ((c / 4) % 4)) : 4'b0000;
            chk_cnt++;
            if (bus.grant !== exp_g) $display("FAIL rr_grant c=%0d got %b exp %b", c, bus.grant, exp_g); else pass_cnt++;
            chk_cnt++;
            if (bus.done !== (((c % 4) == 2) ? exp_g : 4'b0000))
                $display("FAIL rr_done c=%0d got %b", c, bus.done);
            else pass_cnt++;
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_hold();
        logic [7:0] exp_c [10];
        logic [3:0] exp_g;
        exp_c = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5};
        do_reset();
        bus.dur[2] = 8'd5;
        bus.req    = 4'b0100;
        for (int n = 0; n <= 10; n++) begin
            step();
            if (n == 0) begin
                bus.req    = 4'b0000;
                bus.dur[2] = 8'd1;
            end
            exp_g = (n <= 9) ? 4'b0100 : 4'b0000;
            chk_cnt++;
            if (bus.grant !== exp_g) $display("FAIL hold_grant n=%0d got %b exp %b", n, bus.grant, exp_g); else pass_cnt++;
            chk_cnt++;
            if (bus.done !== ((n == 9) ? 4'b0100 : 4'b0000))
                $display("FAIL hold_done n=%0d got %b", n, bus.done);
            else pass_cnt++;
            if (n >= 1 && n <= 9) begin
                chk_cnt++;
                if (bus.contador !== exp_c[n]) $display("FAIL hold_contador n=%0d got %0d exp %0d", n, bus.contador, exp_c[n]); else pass_cnt++;
            end
            bus.hold = (n == 3 || n == 4);
        end
        bus.hold = 1'b0;
    endtask

    task automatic test_abort();
        logic done_seen;
        done_seen = 1'b0;
        do_reset();
        bus.dur[1] = 8'd200;
        bus.dur[2] = 8'd7;
        bus.req    = 4'b0110;
        for (int n = 0; n <= 51; n++) begin
            step();
            if (n == 0) bus.req = 4'b0100;
            if (bus.done !== 4'b0000) done_seen = 1'b1;
        end
        chk_cnt++;
        if (bus.grant !== 4'b0010) $display("FAIL abort_pre_grant got %b exp 0010", bus.grant); else pass_cnt++;
        chk_cnt++;
        if (bus.contador !== 8'd50) $display("FAIL abort_pre_contador got %0d exp 50", bus.contador); else pass_cnt++;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        if (bus.done !== 4'b0000) done_seen = 1'b1;
        chk_cnt++;
        if (bus.grant !== 4'b0000) $display("FAIL abort_grant got %b exp 0000", bus.grant); else pass_cnt++;
        chk_cnt++;
        if (bus.contador !== 8'd0) $display("FAIL abort_contador got %0d exp 0", bus.contador); else pass_cnt++;
        chk_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", bus.busy); else pass_cnt++;
        step();
        if (bus.done !== 4'b0000) done_seen = 1'b1;
        chk_cnt++;
        if (bus.grant !== 4'b0100) $display("FAIL abort_next_grant got %b exp 0100", bus.grant); else pass_cnt++;
        chk_cnt++;
        if (done_seen !== 1'b0) $display("FAIL abort_no_done got %b exp 0", done_seen); else pass_cnt++;
        bus.req = 4'b0000;
    endtask

    task automatic test_abort_at_end();
        do_reset();
        bus.dur[0] = 8'd2;
        bus.req    = 4'b0001;
        for (int n = 0; n <= 3; n++) begin
            step();
            if (n == 0) bus.req = 4'b0000;
        end
        chk_cnt++;
        if (bus.contador !== 8'd2) $display("FAIL abend_pre_contador got %0d exp 2", bus.contador); else pass_cnt++;
        bus.abort = 1'b1;
        bus.hold  = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.hold  = 1'b0;
        chk_cnt++;
        if (bus.done !== 4'b0000) $display("FAIL abend_done got %b exp 0000", bus.done); else pass_cnt++;
        chk_cnt++;
        if (bus.grant !== 4'b0000) $display("FAIL abend_grant got %b exp 0000", bus.grant); else pass_cnt++;
        chk_cnt++;
        if (bus.contador !== 8'd0) $display("FAIL abend_contador got %0d exp 0", bus.contador); else pass_cnt++;
        // Pointer stays past requester 0, so requester 1 wins next.
        bus.req = 4'b0011;
        step();
        bus.req = 4'b0000;
        chk_cnt++;
        if (bus.grant !== 4'b0010) $display("FAIL abend_ptr_grant got %b exp 0010", bus.grant); else pass_cnt++;
    endtask

    task automatic test_max_dur();
        logic       wrap_seen;
        logic       stray_done;
        logic [7:0] prev_c;
        wrap_seen  = 1'b0;
        stray_done = 1'b0;
        prev_c     = 8'd0;
        do_reset();
        bus.dur[3] = 8'd255;
        bus.req    = 4'b1000;
        for (int n = 0; n <= 258; n++) begin
            step();
            if (n == 0) bus.req = 4'b0000;
            if (n >= 2 && n <= 257 && bus.contador < prev_c) wrap_seen = 1'b1;
            prev_c = bus.contador;
            if (n == 257) begin
                chk_cnt++;
                if (bus.done !== 4'b1000) $display("FAIL max_done got %b exp 1000", bus.done); else pass_cnt++;
                chk_cnt++;
                if (bus.contador !== 8'd255) $display("FAIL max_contador got %0d exp 255", bus.contador); else pass_cnt++;
            end else if (bus.done !== 4'b0000) begin
                stray_done = 1'b1;
            end
        end
        chk_cnt++;
        if (wrap_seen !== 1'b0) $display("FAIL max_wrap got %b exp 0", wrap_seen); else pass_cnt++;
        chk_cnt++;
        if (stray_done !== 1'b0) $display("FAIL max_stray_done got %b exp 0", stray_done); else pass_cnt++;
        chk_cnt++;
        if (bus.grant !== 4'b0000) $display("FAIL max_end_grant got %b exp 0000", bus.grant); else pass_cnt++;
        // Repeat run, then asynchronous reset in the middle of RUN.
        bus.req = 4'b1000;
        for (int n = 0; n <= 12; n++) begin
            step();
            if (n == 0) bus.req = 4'b0000;
        end
        chk_cnt++;
        if (bus.contador !== 8'd11) $display("FAIL rst_pre_contador got %0d exp 11", bus.contador); else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (bus.grant !== 4'b0000) $display("FAIL rst_mid_grant got %b exp 0000", bus.grant); else pass_cnt++;
        chk_cnt++;
        if (bus.done !== 4'b0000) $display("FAIL rst_mid_done got %b exp 0000", bus.done); else pass_cnt++;
        chk_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", bus.busy); else pass_cnt++;
        chk_cnt++;
        if (bus.contador !== 8'd0) $display("FAIL rst_mid_contador got %0d exp 0", bus.contador); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        chk_cnt   = 0;
        pass_cnt  = 0;
        rst       = 1'b0;
        bus.req   = 4'b0000;
        bus.dur   = 32'd0;
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_abort();
        test_abort_at_end();
        test_max_dur();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Round-robin scheduler that shares one 8-bit up-counter among NREQ requesters. Each requester asks for a timed interval of a given duration. The block grants one requester at a time, clears and runs the counter for that interval, and pulses a per-requester done. It sits directly above the counter core and is the only block that drives the counter's enable and clear.

## Interface
- NREQ, 4: number of requesters (2..8)
- WIDTH, 8: counter and duration width
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- req  in  NREQ  level request, one bit per requester
- dur  in  NREQ x WIDTH  requested duration per requester; sampled only at the grant edge
- hold  in  1  freezes the counter while in RUN
- abort  in  1  cancels the active job
- grant  out  NREQ  one-hot owner, or all zero
- done  out  NREQ  one-cycle completion pulse to the owner
- busy  out  1  high whenever grant is non-zero
- contador  out  WIDTH  live counter value

## Operation
- Reset values: state IDLE, grant 0, done 0, busy 0, contador 0. Round-robin pointer is set so requester 0 has highest priority.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req is high, pick the first requester at or after the pointer, wrapping modulo NREQ.
  - Set grant to that requester, latch its dur into d_lat, go to LOAD.
  - Advance the pointer to the granted index + 1.
- LOAD: clear the counter to 0, then go to RUN. This state lasts exactly one cycle.
- RUN:
  - If contador == d_lat, go to DONE.
  - Otherwise, if hold is low, increment contador. If hold is high, contador holds.
- DONE:
  - done[owner] = 1 for this cycle only.
  - contador holds its final value (d_lat).
  - Next state is IDLE, where grant drops.
- Arithmetic: contador is unsigned WIDTH-bit. It never wraps, because it stops at d_lat ≤ 2^WIDTH−1. dur = 0 is legal and gives one RUN cycle.
- Requester behaviour:
  - Deasserting req while granted does not cancel the job.
  - Requests that arrive during a job wait. Only IDLE arbitrates.
- abort in LOAD or RUN:
  - Next state is IDLE, grant goes to 0, contador is cleared to 0, and no done is pulsed.
  - The pointer still stays advanced past the aborted requester.
- abort in IDLE or DONE is ignored. A done in progress always completes.
- If abort and hold are both high, abort wins.
- If abort is high in the same cycle RUN reaches contador == d_lat, abort wins and no done is pulsed.
- Reset asserted mid-job: all outputs return immediately (asynchronously) to their reset values. No done is pulsed.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Request to grant: 1 edge. A req seen high at edge k in IDLE gives grant valid after edge k.
- For duration d with no hold:
  - LOAD lasts 1 cycle, RUN lasts d+1 cycles, DONE lasts 1 cycle.
  - grant and busy stay high for d+3 cycles.
  - done is high in the last of those cycles.
- Every hold cycle in RUN extends the job by one cycle.
- There is at least one IDLE cycle between consecutive grants.
- d_lat is stable from the grant edge to the end of DONE. Changes on dur during a job have no effect.

## Structure
- Package counter_pkg:
  - sched_state_t enum (IDLE, LOAD, RUN, DONE)
  - WIDTH_DEFAULT = 8
  - NREQ_MAX = 8
- Sub-module count8_core:
  - Ports: clk, rst, enable, clear, contador.
  - Synchronous clear has priority over enable.
  - Async active-low reset to 0.
  - The scheduler drives clear in LOAD and on abort, and enable = (state==RUN && !hold && contador!=d_lat).
- Round-robin selection is a combinational function inside the scheduler. The pointer register and grant register live in the top level.

## Test plan
- Reset, then req=4'b0001 with dur[0]=3: grant=0001 for 6 cycles. contador goes 0,1,2,3 during RUN. done[0] pulses once with contador=3. busy then falls.
- req=4'b1111 held, all dur=0: grants appear in order 0001, 0010, 0100, 1000, 0001. Each lasts 3 cycles, with one IDLE cycle between grants.
- dur[2]=5, hold high for 2 cycles when contador=2: contador stays at 2 for those cycles. grant lasts 10 cycles and done[2] still pulses.
- dur[1]=200, abort at contador=50: next cycle grant=0, contador=0, no done pulse. A pending req[2] is granted after one IDLE cycle.
- dur[3]=255: contador reaches 255 and done[3] pulses, with no wrap to 0. rst pulled low mid-RUN on a repeat run: grant, done, busy and contador are all 0 immediately.
